// File: rtl/conf_int_add_noff_multiple_add.sv
// conf_int_add_noff_multiple_add
//   Configurable-accuracy integer adder. The operand-to-result path is purely
//   combinational. The only state is a 3-bit mode register that is loaded from
//   conf_select on every rising clock edge.
//
//   Mode 0 gives the exact sum modulo 2^DATA_PATH_BITWIDTH.
//   Modes 1..7 use a lower-part-OR adder when APX_LOA_EN is defined.
//     - The approximation width is k = min(4*mode, DATA_PATH_BITWIDTH-1).
//     - The low k bits are a|b.
//     - The upper bits are a + b, plus a carry-in of a[k-1]&b[k-1].
//   With APX_LOA_EN undefined, every mode gives the exact sum.
//   The mode register still exists and still resets to 0.
//
//   Macro: APX_LOA_EN (enables the approximate modes)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset (forces exact mode)
//   a, b         in   [OP_BITWIDTH-1:0] two's-complement operands
//   conf_select  in   [2:0] requested mode, takes effect after the next clk edge
//   c            out  [OP_BITWIDTH-1:0] sum, sign-extended above the datapath
module conf_int_add_noff_multiple_add #(
    parameter int OP_BITWIDTH        = 32,
    parameter int DATA_PATH_BITWIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OP_BITWIDTH-1:0] a,
    input  logic [OP_BITWIDTH-1:0] b,
    input  logic [2:0]             conf_select,
    output logic [OP_BITWIDTH-1:0] c
);

    localparam int DP = DATA_PATH_BITWIDTH;

    logic [2:0]    r_conf_q;
    logic [DP-1:0] w_a;
    logic [DP-1:0] w_b;
    logic [DP-1:0] w_sum;

    // An asynchronous clear puts the adder into exact mode as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_conf_q <= 3'd0;
        else     r_conf_q <= conf_select;
    end

    assign w_a = a[DP-1:0];
    assign w_b = b[DP-1:0];

`ifdef APX_LOA_EN
    localparam logic [7:0] K_MAX = 8'(DP-1);

    logic [7:0]    w_k;
    logic [DP-1:0] w_lo_mask;
    logic [DP-1:0] w_hi_mask;
    logic          w_cin;
    logic [DP-1:0] w_hi;

    // In mode 0, k is 0 and the mask is empty, so this same path gives the
    // exact sum. No separate exact adder is needed.
    always_comb begin
        w_k = {3'b000, r_conf_q, 2'b00};
        if (w_k > K_MAX) w_k = K_MAX;
        w_lo_mask = ~({DP{1'b1}} << w_k);
        w_hi_mask = ~w_lo_mask;
        // The top bit of the low mask selects bit k-1. When k is 0, there is no carry.
        w_cin     = |(w_a & w_b & (w_lo_mask ^ (w_lo_mask >> 1)));
        w_hi      = ((w_a & w_hi_mask) + (w_b & w_hi_mask)
                     + ({{(DP-1){1'b0}}, w_cin} << w_k)) & w_hi_mask;
        w_sum     = w_hi | ((w_a | w_b) & w_lo_mask);
    end
`else
    logic w_unused_conf;

    assign w_unused_conf = ^r_conf_q;
    assign w_sum         = w_a + w_b;
`endif

    generate
        if (OP_BITWIDTH > DP) begin : g_sext
            assign c = {{(OP_BITWIDTH-DP){w_sum[DP-1]}}, w_sum};
        end else begin : g_nosext
            assign c = w_sum;
        end
    endgenerate

endmodule

// File: tb/tb_conf_int_add_noff_multiple_add.sv
// Directed bench with a scoreboard.
//   - The stimulus drives operands and the mode just after a rising edge.
//   - It pushes the hand-computed results into a queue.
//   - A monitor samples on the falling edge, pops the queue and compares.
//   - Two instances share the inputs:
//       dut32 has a full 32-bit datapath.
//       dut8  has an 8-bit datapath inside 32-bit ports, which exercises
//       upper-bit masking and sign extension.
module tb_conf_int_add_noff_multiple_add;

`ifdef APX_LOA_EN
    localparam bit APX = 1'b1;
`else
    localparam bit APX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  conf_select = '0;
    logic [31:0] c32;
    logic [31:0] c8;

    typedef struct {
        string       name;
        logic [31:0] e32;
        logic [31:0] e8;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    conf_int_add_noff_multiple_add #(.OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .a(a), .b(b), .conf_select(conf_select), .c(c32));

    conf_int_add_noff_multiple_add #(.OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .conf_select(conf_select), .c(c8));

    // Apply one vector just after a rising edge, then queue its expected results.
    task automatic step(input string nm, input logic r, input logic [2:0] cs,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] x32, input logic [31:0] x8);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        conf_select = cs;
        a           = va;
        b           = vb;
        e.name = nm;
        e.e32  = x32;
        e.e8   = x8;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (c32 !== e.e32) begin
                    errors++;
                    $display("FAIL %s dp32: got %h want %h", e.name, c32, e.e32);
                end
                checks++;
                if (c8 !== e.e8) begin
                    errors++;
                    $display("FAIL %s dp8: got %h want %h", e.name, c8, e.e8);
                end
            end
        end
    end

    initial begin
        // The mode is held at 0 by reset.
        step("rst_5p7",    1, 3'd1, 32'h5, 32'h7, 32'hC, 32'hC);
        step("rst_Fp1",    1, 3'd1, 32'hF, 32'h1, 32'h10, 32'h10);
        // Release reset. No edge has loaded the mode yet, so the sum is still exact.
        step("rel_nomode", 0, 3'd1, 32'hF, 32'h1, 32'h10, 32'h10);
        step("m1_Fp1",     0, 3'd1, 32'hF, 32'h1,
             APX ? 32'hF : 32'h10, APX ? 32'hF : 32'h10);
        step("m1_8p8",     0, 3'd1, 32'h8, 32'h8,
             APX ? 32'h18 : 32'h10, APX ? 32'h18 : 32'h10);
        step("m1_12p21",   0, 3'd1, 32'h12, 32'h21, 32'h33, 32'h33);
        // A new mode and new operands arrive together. The operands apply now
        // and the new mode applies after the next edge.
        step("sw0_Fp1",    0, 3'd0, 32'hF, 32'h1,
             APX ? 32'hF : 32'h10, APX ? 32'hF : 32'h10);
        step("m0_wrap",    0, 3'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0);
        step("m0_neg3p5",  0, 3'd0, 32'hFFFFFFFD, 32'h5, 32'h2, 32'h2);
        step("m0_ovf",     0, 3'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0);
        step("m0_sext",    0, 3'd0, 32'h7F, 32'h1, 32'h80, 32'hFFFFFF80);
        step("m0_hiign",   0, 3'd0, 32'hABCD0003, 32'h12340004, 32'hBE010007, 32'h7);
        step("sw7",        0, 3'd7, 32'h0, 32'h0, 32'h0, 32'h0);
        step("m7_kmax",    0, 3'd7, 32'h0FFFFFFF, 32'h1,
             APX ? 32'h0FFFFFFF : 32'h10000000, APX ? 32'hFFFFFFFF : 32'h0);
        step("m7_carry",   0, 3'd7, 32'h18000000, 32'h18000000,
             APX ? 32'h38000000 : 32'h30000000, 32'h0);
        step("sw3",        0, 3'd3, 32'h0, 32'h0, 32'h0, 32'h0);
        step("m3_FFFp1",   0, 3'd3, 32'hFFF, 32'h1,
             APX ? 32'hFFF : 32'h1000, APX ? 32'hFFFFFFFF : 32'h0);
        step("sw1",        0, 3'd1, 32'h0, 32'h0, 32'h0, 32'h0);
        step("m1_again",   0, 3'd1, 32'hF, 32'h1,
             APX ? 32'hF : 32'h10, APX ? 32'hF : 32'h10);
        // Assert reset with no clock edge in between. The result must become
        // exact immediately.
        step("rst_async",  1, 3'd1, 32'hF, 32'h1, 32'h10, 32'h10);
        step("rst_hold",   1, 3'd1, 32'hF, 32'h1, 32'h10, 32'h10);
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conf_int_add_noff_multiple_add.md
CONF_INT_ADD_NOFF_MULTIPLE_ADD -- requirements
Module: conf_int_add__noFF__multiple_add

Interface
REQ-001 Parameter OP_BITWIDTH, default 32: width of ports a, b, c.
REQ-002 Parameter DATA_PATH_BITWIDTH, default 32: number of low-order bits actually added; must be between 2 and OP_BITWIDTH inclusive.
REQ-003 clk  input  1: single clock; rising edge active.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 a  input  OP_BITWIDTH: operand A, two's complement.
REQ-006 b  input  OP_BITWIDTH: operand B, two's complement.
REQ-007 conf_select  input  3: approximation mode request.
REQ-008 c  output  OP_BITWIDTH: sum, two's complement.

Function
REQ-009 The datapath from a and b to c SHALL be purely combinational: no flip-flops on operands or result.
REQ-010 The only state element SHALL be a 3-bit mode register conf_q, loaded from conf_select on each rising clk edge while rst is low.
REQ-011 A change on conf_select SHALL take effect on c only after the next rising clk edge.
REQ-012 Only bits [DATA_PATH_BITWIDTH-1:0] of a and b SHALL be used.
REQ-013 Bits of a and b above DATA_PATH_BITWIDTH-1 SHALL be ignored.
REQ-014 Bits of c above DATA_PATH_BITWIDTH-1 SHALL be sign-extended from c[DATA_PATH_BITWIDTH-1].
REQ-015 Mode conf_q=0 SHALL produce the exact sum modulo 2^DATA_PATH_BITWIDTH; overflow wraps and no carry-out or overflow flag is produced.
REQ-016 Modes 1..7 SHALL use a lower-part-OR adder with approximation width k = min(4*conf_q, DATA_PATH_BITWIDTH-1).
REQ-017 In modes 1..7, c[k-1:0] SHALL equal a[k-1:0] OR b[k-1:0].
REQ-018 In modes 1..7, c[DATA_PATH_BITWIDTH-1:k] SHALL equal a[DP-1:k] + b[DP-1:k] + (a[k-1] AND b[k-1]), modulo 2^(DP-k), where DP = DATA_PATH_BITWIDTH.
REQ-019 c SHALL settle within the same clock cycle that a or b changes, so that a value sampled one clock period after an input change is valid.
REQ-020 Simultaneous conf_select change and operand change: operands apply immediately; the new mode applies after the clock edge.

Reset
REQ-021 While rst is high, conf_q SHALL be 0 asynchronously, without waiting for a clk edge.
REQ-022 While rst is high, c SHALL be the exact sum of a and b; c is not forced to zero.
REQ-023 If rst is asserted mid-operation in an approximate mode, c SHALL switch to the exact sum immediately.
REQ-024 After rst deasserts, conf_q SHALL take the value of conf_select at the first rising clk edge.

Configuration
REQ-025 Macro APX_LOA_EN: when defined, modes 1..7 SHALL behave per REQ-016 to REQ-018.
REQ-026 When APX_LOA_EN is undefined, every conf_q value SHALL produce the exact sum (REQ-015); conf_q still exists and resets to 0.

Verification
REQ-027 rst=1, conf_select=1, a=5, b=7 -> c=12 (exact mode held by reset).
REQ-028 rst=0, conf_select=1, one clk edge, then a=0x0000000F, b=0x00000001 -> c=0x0000000F (the exact sum would be 0x10).
REQ-029 Mode 1, a=0x00000008, b=0x00000008 -> c=0x00000018 (carry from a[3] AND b[3]).
REQ-030 Mode 0: a=0xFFFFFFFF, b=1 -> c=0x00000000; a=0xFFFFFFFD (-3), b=5 -> c=2.
REQ-031 Mode 1 active with a=0xF, b=1 (c=0xF); assert rst with no clk edge -> c=0x10 immediately.
REQ-032 APX_LOA_EN undefined, mode 1, a=0xF, b=1 -> c=0x10.
